// File: rtl/riscv32ima_pkg.sv
// Shared constants and types for the RV32IMA issue path.
package riscv32ima_pkg;

  localparam int unsigned NUM_REGS = 32;

  // Base opcode map (instr[6:0])
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic {
    ISSUE_EMPTY = 1'b0,
    ISSUE_FULL  = 1'b1
  } issue_state_e;

endpackage

// File: rtl/riscv32ima_scoreboard.sv
// Register scoreboard: one pending bit per GPR plus an in-flight write counter.
module riscv32ima_scoreboard
  import riscv32ima_pkg::*;
#(
  parameter int unsigned REG_ADDR_WIDTH  = 5,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned CNT_WIDTH       = 3
) (
  input  logic                      clk,
  input  logic                      nrst,
  input  logic                      set_en,
  input  logic [REG_ADDR_WIDTH-1:0] set_addr,
  input  logic                      clr_en,
  input  logic [REG_ADDR_WIDTH-1:0] clr_addr,
  input  logic                      q0_used,
  input  logic [REG_ADDR_WIDTH-1:0] q0_addr,
  input  logic                      q1_used,
  input  logic [REG_ADDR_WIDTH-1:0] q1_addr,
  input  logic                      q2_used,
  input  logic [REG_ADDR_WIDTH-1:0] q2_addr,
  output logic [NUM_REGS-1:0]       pending_mask,
  output logic [CNT_WIDTH-1:0]      outstanding,
  output logic                      hazard_c,
  output logic                      at_limit_c
);

  logic [NUM_REGS-1:0] clr_vec;
  logic [NUM_REGS-1:0] set_vec;
  logic [NUM_REGS-1:0] pend_eff;
  logic                set_ok;
  logic                dec;

  // Same-cycle writeback bypass and hazard/limit queries
  always_comb begin
    clr_vec    = '0;
    set_vec    = '0;
    set_ok     = set_en & (set_addr != '0);
    dec        = clr_en & (clr_addr != '0) & pending_mask[clr_addr];
    if (clr_en) clr_vec = NUM_REGS'(1) << clr_addr;
    if (set_ok) set_vec = NUM_REGS'(1) << set_addr;
    pend_eff   = pending_mask & ~clr_vec;
    hazard_c   = (q0_used & (q0_addr != '0) & pend_eff[q0_addr]) |
                 (q1_used & (q1_addr != '0) & pend_eff[q1_addr]) |
                 (q2_used & (q2_addr != '0) & pend_eff[q2_addr]);
    at_limit_c = (outstanding == CNT_WIDTH'(MAX_OUTSTANDING)) & ~dec;
  end

  // Pending bits (set wins over clear) and in-flight counter
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      pending_mask <= '0;
      outstanding  <= '0;
    end else begin
      pending_mask <= ((pending_mask & ~clr_vec) | set_vec) & ~NUM_REGS'(1);
      case ({set_ok, dec})
        2'b10:   outstanding <= outstanding + CNT_WIDTH'(1);
        2'b01:   outstanding <= outstanding - CNT_WIDTH'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

endmodule

// File: rtl/riscv32ima_issue_ctrl.sv
// Single-entry issue stage: holds one decoded instruction until its
// operands and destination are free, then hands it to execute.
module riscv32ima_issue_ctrl
  import riscv32ima_pkg::*;
#(
  parameter int unsigned REG_ADDR_WIDTH  = 5,
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned OPCODE_WIDTH    = 7,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned CNT_WIDTH       = 3
) (
  input  logic                      clk,
  input  logic                      nrst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [ADDR_WIDTH-1:0]     in_pc,
  input  logic [OPCODE_WIDTH-1:0]   in_opcode,
  input  logic [REG_ADDR_WIDTH-1:0] in_src0_addr,
  input  logic                      in_src0_used,
  input  logic [REG_ADDR_WIDTH-1:0] in_src1_addr,
  input  logic                      in_src1_used,
  input  logic [REG_ADDR_WIDTH-1:0] in_dst_addr,
  input  logic                      in_dst_wen,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [ADDR_WIDTH-1:0]     out_pc,
  output logic [OPCODE_WIDTH-1:0]   out_opcode,
  output logic [REG_ADDR_WIDTH-1:0] out_src0_addr,
  output logic [REG_ADDR_WIDTH-1:0] out_src1_addr,
  output logic [REG_ADDR_WIDTH-1:0] out_dst_addr,
  output logic                      out_dst_wen,
  input  logic                      wback_reg_wen,
  input  logic [REG_ADDR_WIDTH-1:0] wback_reg_addr,
  input  logic                      wback_pc_wen,
  output logic [NUM_REGS-1:0]       pending_mask,
  output logic [CNT_WIDTH-1:0]      outstanding,
  output logic                      stall
);

  issue_state_e state_q;
  logic         src0_used_q;
  logic         src1_used_q;
  logic         hazard;
  logic         at_limit;
  logic         limit;
  logic         full;
  logic         issue;
  logic         accept;

  riscv32ima_scoreboard #(
    .REG_ADDR_WIDTH (REG_ADDR_WIDTH),
    .MAX_OUTSTANDING(MAX_OUTSTANDING),
    .CNT_WIDTH      (CNT_WIDTH)
  ) u_scoreboard (
    .clk         (clk),
    .nrst        (nrst),
    .set_en      (issue & out_dst_wen),
    .set_addr    (out_dst_addr),
    .clr_en      (wback_reg_wen),
    .clr_addr    (wback_reg_addr),
    .q0_used     (src0_used_q),
    .q0_addr     (out_src0_addr),
    .q1_used     (src1_used_q),
    .q1_addr     (out_src1_addr),
    .q2_used     (out_dst_wen),
    .q2_addr     (out_dst_addr),
    .pending_mask(pending_mask),
    .outstanding (outstanding),
    .hazard_c    (hazard),
    .at_limit_c  (at_limit)
  );

  // Handshake decode; a PC redirect blocks both sides for the cycle
  always_comb begin
    full      = (state_q == ISSUE_FULL);
    limit     = out_dst_wen & (out_dst_addr != '0) & at_limit;
    stall     = full & (hazard | limit);
    out_valid = full & ~hazard & ~limit & ~wback_pc_wen;
    issue     = out_valid & out_ready;
    in_ready  = ~wback_pc_wen & (~full | issue);
    accept    = in_valid & in_ready;
  end

  // Holding register and EMPTY/FULL state
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q       <= ISSUE_EMPTY;
      out_pc        <= '0;
      out_opcode    <= '0;
      out_src0_addr <= '0;
      out_src1_addr <= '0;
      out_dst_addr  <= '0;
      out_dst_wen   <= 1'b0;
      src0_used_q   <= 1'b0;
      src1_used_q   <= 1'b0;
    end else if (wback_pc_wen) begin
      state_q <= ISSUE_EMPTY;
    end else if (accept) begin
      state_q       <= ISSUE_FULL;
      out_pc        <= in_pc;
      out_opcode    <= in_opcode;
      out_src0_addr <= in_src0_addr;
      out_src1_addr <= in_src1_addr;
      out_dst_addr  <= in_dst_addr;
      out_dst_wen   <= in_dst_wen;
      src0_used_q   <= in_src0_used;
      src1_used_q   <= in_src1_used;
    end else if (issue) begin
      state_q <= ISSUE_EMPTY;
    end
  end

endmodule

// File: tb/tb_riscv32ima_issue_ctrl.sv
// Directed bench for the single-entry issue controller.
module tb_riscv32ima_issue_ctrl;

  logic        clk = 1'b0;
  logic        nrst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [6:0]  in_opcode;
  logic [4:0]  in_src0_addr;
  logic        in_src0_used;
  logic [4:0]  in_src1_addr;
  logic        in_src1_used;
  logic [4:0]  in_dst_addr;
  logic        in_dst_wen;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [6:0]  out_opcode;
  logic [4:0]  out_src0_addr;
  logic [4:0]  out_src1_addr;
  logic [4:0]  out_dst_addr;
  logic        out_dst_wen;
  logic        wback_reg_wen;
  logic [4:0]  wback_reg_addr;
  logic        wback_pc_wen;
  logic [31:0] pending_mask;
  logic [2:0]  outstanding;
  logic        stall;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  riscv32ima_issue_ctrl dut (
    .clk           (clk),
    .nrst          (nrst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_pc         (in_pc),
    .in_opcode     (in_opcode),
    .in_src0_addr  (in_src0_addr),
    .in_src0_used  (in_src0_used),
    .in_src1_addr  (in_src1_addr),
    .in_src1_used  (in_src1_used),
    .in_dst_addr   (in_dst_addr),
    .in_dst_wen    (in_dst_wen),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_pc        (out_pc),
    .out_opcode    (out_opcode),
    .out_src0_addr (out_src0_addr),
    .out_src1_addr (out_src1_addr),
    .out_dst_addr  (out_dst_addr),
    .out_dst_wen   (out_dst_wen),
    .wback_reg_wen (wback_reg_wen),
    .wback_reg_addr(wback_reg_addr),
    .wback_pc_wen  (wback_pc_wen),
    .pending_mask  (pending_mask),
    .outstanding   (outstanding),
    .stall         (stall)
  );

  // Move to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [4:0] rd,
                       input logic wen, input logic [4:0] rs1, input logic u0,
                       input logic [4:0] rs2, input logic u1);
    in_valid     = v;
    in_pc        = pc;
    in_opcode    = 7'b0110011;
    in_dst_addr  = rd;
    in_dst_wen   = wen;
    in_src0_addr = rs1;
    in_src0_used = u0;
    in_src1_addr = rs2;
    in_src1_used = u1;
  endtask

  // One-cycle register writeback pulse
  task automatic wb(input logic [4:0] a);
    step();
    wback_reg_wen  = 1'b1;
    wback_reg_addr = a;
    step();
    wback_reg_wen  = 1'b0;
    wback_reg_addr = 5'd0;
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    drive(1'b0, 32'h0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    out_ready = 1'b0; wback_reg_wen = 1'b0; wback_reg_addr = 5'd0; wback_pc_wen = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b want=0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%0b want=1", in_ready); end
    total++; if (pending_mask !== 32'h0) begin bad++; $display("FAIL reset_pending got=%h want=0", pending_mask); end
    total++; if (outstanding !== 3'd0) begin bad++; $display("FAIL reset_outstanding got=%0d want=0", outstanding); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%0b want=0", stall); end
    total++; if (out_pc !== 32'h0) begin bad++; $display("FAIL reset_out_pc got=%h want=0", out_pc); end
    nrst = 1'b1;
  endtask

  task automatic test_basic_issue();
    step();
    drive(1'b1, 32'h100, 5'd5, 1'b1, 5'd1, 1'b1, 5'd2, 1'b1);
    out_ready = 1'b0;
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_lat0_valid got=%0b want=0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL basic_empty_ready got=%0b want=1", in_ready); end
    step();
    drive(1'b1, 32'h104, 5'd6, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    @(negedge clk);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%0b want=1", out_valid); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL basic_full_ready got=%0b want=0", in_ready); end
    total++; if (out_pc !== 32'h100) begin bad++; $display("FAIL basic_pc got=%h want=100", out_pc); end
    total++; if ({out_dst_addr, out_src0_addr, out_src1_addr} !== {5'd5, 5'd1, 5'd2}) begin
      bad++; $display("FAIL basic_regs got=%0d/%0d/%0d want=5/1/2", out_dst_addr, out_src0_addr, out_src1_addr); end
    step();
    @(negedge clk);
    total++; if (out_pc !== 32'h100 || out_valid !== 1'b1) begin
      bad++; $display("FAIL basic_hold got pc=%h v=%0b want pc=100 v=1", out_pc, out_valid); end
    step();
    drive(1'b0, 32'h0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    out_ready = 1'b1;
    @(negedge clk);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL basic_issue_ready got=%0b want=1", in_ready); end
    step();
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_empty_after got=%0b want=0", out_valid); end
    total++; if (pending_mask !== 32'h0000_0020) begin bad++; $display("FAIL basic_pending got=%h want=00000020", pending_mask); end
    total++; if (outstanding !== 3'd1) begin bad++; $display("FAIL basic_outstanding got=%0d want=1", outstanding); end
  endtask

  task automatic test_raw_bypass();
    step();
    drive(1'b1, 32'h120, 5'd6, 1'b1, 5'd5, 1'b1, 5'd0, 1'b0);
    step();
    drive(1'b0, 32'h0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    @(negedge clk);
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL raw_stall got=%0b want=1", stall); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL raw_blocked got=%0b want=0", out_valid); end
    step();
    wback_reg_wen = 1'b1; wback_reg_addr = 5'd5;
    @(negedge clk);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL raw_bypass_valid got=%0b want=1", out_valid); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL raw_bypass_stall got=%0b want=0", stall); end
    step();
    wback_reg_wen = 1'b0; wback_reg_addr = 5'd0;
    @(negedge clk);
    total++; if (pending_mask !== 32'h0000_0040) begin bad++; $display("FAIL raw_pending got=%h want=00000040", pending_mask); end
    total++; if (outstanding !== 3'd1) begin bad++; $display("FAIL raw_outstanding got=%0d want=1", outstanding); end
    wb(5'd6);
    @(negedge clk);
    total++; if (pending_mask !== 32'h0 || outstanding !== 3'd0) begin
      bad++; $display("FAIL raw_drain got pm=%h cnt=%0d want pm=0 cnt=0", pending_mask, outstanding); end
  endtask

  task automatic test_limit();
    for (int i = 1; i <= 5; i++) begin
      step();
      drive(1'b1, 32'h200 + 32'(4 * i), 5'(i), 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
      @(negedge clk);
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL limit_stream_ready%0d got=%0b want=1", i, in_ready); end
    end
    step();
    drive(1'b0, 32'h0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    @(negedge clk);
    total++; if (stall !== 1'b1 || out_valid !== 1'b0) begin
      bad++; $display("FAIL limit_stall got st=%0b v=%0b want st=1 v=0", stall, out_valid); end
    total++; if (outstanding !== 3'd4) begin bad++; $display("FAIL limit_count got=%0d want=4", outstanding); end
    total++; if (pending_mask !== 32'h0000_001E) begin bad++; $display("FAIL limit_pending got=%h want=0000001e", pending_mask); end
    total++; if (out_dst_addr !== 5'd5) begin bad++; $display("FAIL limit_held_rd got=%0d want=5", out_dst_addr); end
    step();
    wback_reg_wen = 1'b1; wback_reg_addr = 5'd1;
    @(negedge clk);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL limit_release got=%0b want=1", out_valid); end
    step();
    wback_reg_wen = 1'b0; wback_reg_addr = 5'd0;
    @(negedge clk);
    total++; if (outstanding !== 3'd4) begin bad++; $display("FAIL limit_count_after got=%0d want=4", outstanding); end
    total++; if (pending_mask !== 32'h0000_003C) begin bad++; $display("FAIL limit_pending_after got=%h want=0000003c", pending_mask); end
    for (int r = 2; r <= 5; r++) wb(5'(r));
    @(negedge clk);
    total++; if (pending_mask !== 32'h0 || outstanding !== 3'd0) begin
      bad++; $display("FAIL limit_drain got pm=%h cnt=%0d want pm=0 cnt=0", pending_mask, outstanding); end
  endtask

  task automatic test_set_wins();
    step();
    drive(1'b1, 32'h300, 5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    step();
    drive(1'b0, 32'h0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    step();
    drive(1'b1, 32'h304, 5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    step();
    drive(1'b0, 32'h0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    @(negedge clk);
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL waw_stall got=%0b want=1", stall); end
    total++; if (pending_mask !== 32'h0000_0080 || outstanding !== 3'd1) begin
      bad++; $display("FAIL waw_state got pm=%h cnt=%0d want pm=00000080 cnt=1", pending_mask, outstanding); end
    step();
    wback_reg_wen = 1'b1; wback_reg_addr = 5'd7;
    @(negedge clk);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL setwin_valid got=%0b want=1", out_valid); end
    step();
    wback_reg_wen = 1'b0; wback_reg_addr = 5'd0;
    @(negedge clk);
    total++; if (pending_mask !== 32'h0000_0080) begin bad++; $display("FAIL setwin_pending got=%h want=00000080", pending_mask); end
    total++; if (outstanding !== 3'd1) begin bad++; $display("FAIL setwin_count got=%0d want=1", outstanding); end
    wb(5'd7);
  endtask

  task automatic test_flush();
    step();
    drive(1'b1, 32'h400, 5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    step();
    drive(1'b1, 32'h404, 5'd10, 1'b1, 5'd9, 1'b1, 5'd0, 1'b0);
    step();
    drive(1'b1, 32'h408, 5'd11, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    wback_pc_wen = 1'b1;
    @(negedge clk);
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL flush_in_ready got=%0b want=0", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_out_valid got=%0b want=0", out_valid); end
    step();
    wback_pc_wen = 1'b0;
    drive(1'b0, 32'h0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    @(negedge clk);
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || stall !== 1'b0) begin
      bad++; $display("FAIL flush_empty got v=%0b r=%0b st=%0b want v=0 r=1 st=0", out_valid, in_ready, stall); end
    total++; if (pending_mask !== 32'h0000_0200 || outstanding !== 3'd1) begin
      bad++; $display("FAIL flush_scoreboard got pm=%h cnt=%0d want pm=00000200 cnt=1", pending_mask, outstanding); end
    wb(5'd3);
    @(negedge clk);
    total++; if (pending_mask !== 32'h0000_0200 || outstanding !== 3'd1) begin
      bad++; $display("FAIL wb_nonpending got pm=%h cnt=%0d want pm=00000200 cnt=1", pending_mask, outstanding); end
    wb(5'd9);
  endtask

  task automatic test_x0_stream();
    for (int i = 0; i < 4; i++) begin
      step();
      drive(1'b1, 32'h500 + 32'(4 * i), 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1);
      wback_reg_wen = 1'b1; wback_reg_addr = 5'd0;
      @(negedge clk);
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL x0_ready%0d got=%0b want=1", i, in_ready); end
      if (i > 0) begin
        total++; if (out_valid !== 1'b1 || out_pc !== 32'h500 + 32'(4 * (i - 1))) begin
          bad++; $display("FAIL x0_issue%0d got v=%0b pc=%h want v=1 pc=%h", i, out_valid, out_pc, 32'h500 + 32'(4 * (i - 1))); end
      end
    end
    step();
    drive(1'b0, 32'h0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    wback_reg_wen = 1'b0;
    @(negedge clk);
    total++; if (pending_mask !== 32'h0 || outstanding !== 3'd0) begin
      bad++; $display("FAIL x0_scoreboard got pm=%h cnt=%0d want pm=0 cnt=0", pending_mask, outstanding); end
    step();
  endtask

  task automatic test_mid_reset();
    step();
    drive(1'b1, 32'h600, 5'd12, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    step();
    drive(1'b0, 32'h0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    step();
    drive(1'b1, 32'h604, 5'd13, 1'b1, 5'd12, 1'b1, 5'd0, 1'b0);
    step();
    drive(1'b0, 32'h0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    @(negedge clk);
    total++; if (pending_mask !== 32'h0000_1000 || stall !== 1'b1) begin
      bad++; $display("FAIL prereset got pm=%h st=%0b want pm=00001000 st=1", pending_mask, stall); end
    #2 nrst = 1'b0;
    #1;
    total++; if (pending_mask !== 32'h0 || outstanding !== 3'd0 || out_valid !== 1'b0 || out_pc !== 32'h0 || stall !== 1'b0) begin
      bad++; $display("FAIL midreset got pm=%h cnt=%0d v=%0b pc=%h st=%0b want all zero",
                      pending_mask, outstanding, out_valid, out_pc, stall); end
    #1 nrst = 1'b1;
  endtask

  initial begin
    test_reset();
    test_basic_issue();
    test_raw_bypass();
    test_limit();
    test_set_wins();
    test_flush();
    test_x0_stream();
    test_mid_reset();
    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/riscv32ima_issue_ctrl.md
Name: riscv32ima_issue_ctrl

Overview:
Scoreboard-based issue controller between the decode stage and execute. Holds one decoded instruction, tracks GPRF registers with a write outstanding, and releases the instruction downstream only when its sources and destination are free. Writeback clears pending bits; a PC redirect squashes the held instruction.

Parameters:
REG_ADDR_WIDTH, 5, GPRF address width (32 registers)
ADDR_WIDTH, 32, instruction address width
OPCODE_WIDTH, 7, opcode field width
MAX_OUTSTANDING, 4, max in-flight register writes (1..31)
CNT_WIDTH, 3, width of outstanding counter, must hold MAX_OUTSTANDING

Ports:
clk  in  1  clock
nrst  in  1  asynchronous active-low reset
in_valid  in  1  decoded instruction valid
in_ready  out  1  controller accepts instruction
in_pc  in  ADDR_WIDTH  instruction PC
in_opcode  in  OPCODE_WIDTH  opcode
in_src0_addr  in  REG_ADDR_WIDTH  rs1
in_src0_used  in  1  rs1 is read
in_src1_addr  in  REG_ADDR_WIDTH  rs2
in_src1_used  in  1  rs2 is read
in_dst_addr  in  REG_ADDR_WIDTH  rd
in_dst_wen  in  1  instruction writes rd
out_valid  out  1  instruction issued to execute
out_ready  in  1  execute accepts
out_pc, out_opcode, out_src0_addr, out_src1_addr, out_dst_addr, out_dst_wen  out  as inputs  held instruction fields
wback_reg_wen  in  1  register writeback strobe
wback_reg_addr  in  REG_ADDR_WIDTH  writeback register
wback_pc_wen  in  1  PC redirect (flush)
pending_mask  out  32  scoreboard bit per register
outstanding  out  CNT_WIDTH  in-flight write count
stall  out  1  held instruction blocked by hazard or count limit

Behaviour:
- Clock clk, reset nrst: asynchronous, active-low. Reset: state EMPTY, out_valid=0, all out_* fields=0, pending_mask=0, outstanding=0, stall=0. Reset mid-operation discards held instruction and all pending state.
- States: EMPTY, FULL. EMPTY: in_ready=1; in_valid -> capture fields, go FULL. FULL: out_valid = ~hazard & ~limit; issue = out_valid & out_ready.
- in_ready = EMPTY | issue. Issue with simultaneous in_valid: capture new instruction, stay FULL (back-to-back, 1 instr/cycle). Issue without in_valid -> EMPTY.
- Latency: accepted cycle N -> out_valid earliest N+1.
- hazard = (src0_used & src0!=0 & pend_eff[src0]) | (src1_used & src1!=0 & pend_eff[src1]) | (dst_wen & dst!=0 & pend_eff[dst]) (WAW stalls too).
- pend_eff = pending_mask with bit wback_reg_addr cleared when wback_reg_wen (same-cycle bypass: writeback in cycle N lets dependent issue in cycle N).
- limit = dst_wen & dst!=0 & (outstanding == MAX_OUTSTANDING) & ~dec, where dec = wback_reg_wen & wback_reg_addr!=0 & pending_mask[wback_reg_addr].
- stall = FULL & (hazard | limit); registered-field semantics, combinational from state.
- Pending update: on issue with dst_wen & dst!=0 set bit dst; on writeback clear bit; same register both events same cycle -> set wins. Bit 0 never set.
- outstanding: +1 on issue-with-write, -1 on dec; both -> unchanged. Writeback to non-pending register or x0 ignored (no decrement, no underflow).
- Flush (wback_pc_wen=1): FULL -> EMPTY, held instruction dropped, out_valid forced 0 that cycle; in_ready=0 that cycle. Scoreboard and counter untouched (issued instructions still complete). Flush outranks issue.
- out_* fields stable while out_valid=1 and out_ready=0.

Decomposition:
- Package riscv32ima_pkg: opcode constants (LOAD, OP_IMM, STORE, BRANCH, JAL, JALR, LUI, AUIPC, OP, SYSTEM), issue-state enum {EMPTY, FULL}, register-count constant 32.
- Sub-module riscv32ima_scoreboard: pending_mask + outstanding counter, set/clear ports, hazard query for three addresses; controller instantiates it.

Test Plan:
- Reset then in_valid with rd=x5,rs1=x1,rs2=x2 -> out_valid cycle 2; after issue pending_mask=0x0000_0020, outstanding=1.
- Next instr rs1=x5 -> stall=1, out_valid=0; wback_reg_wen x5 -> out_valid same cycle, bit 5 cleared then reset if new rd.
- Five independent writes x1..x5 with no writeback, MAX_OUTSTANDING=4 -> fifth stalls, outstanding=4; one writeback -> fifth issues same cycle, outstanding stays 4.
- Issue rd=x7 and writeback x7 same cycle with bit 7 set -> bit 7 remains 1, outstanding unchanged.
- Held stalled instruction plus wback_pc_wen -> EMPTY next cycle, out_valid=0, pending_mask unchanged.
- rd=x0 and rs1=x0 instructions streamed with out_ready=1 -> one issue per cycle, pending_mask=0, outstanding=0; writeback x0 ignored.
